// File: rtl/tff_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for the TFF toggle arbiter.
package tff_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int CNT_W_DEF = 16;
    localparam int MAX_REQ   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TOGGLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    // First set bit of req searching upward from ptr+1, wrapping modulo nreq.
    // Returns 0 when nothing is set; callers qualify the result with |req.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int                 nreq);
        logic [3:0] pick;
        logic [3:0] pos;
        logic       found;
        int         j;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            j   = (int'(ptr) + i) % nreq;
            pos = j[3:0];
            if (i <= nreq && !found && req[pos]) begin
                pick  = pos;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tff_toggle_arbiter_rr_picker.sv
// Combinational round-robin priority search: next requester after ptr, plus any-request flag.
module rr_picker
    import tff_arb_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         ptr_ext;
    logic [3:0]         pick;

    // Widen to the helper's fixed width, search, then narrow back to the index width.
    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        ptr_ext             = '0;
        ptr_ext[IDX_W-1:0]  = ptr;
        pick                = rr_pick(req_ext, ptr_ext, NREQ);
        idx                 = pick[IDX_W-1:0];
        any_req             = |req;
    end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop: one toggle per grant, then verifies q inverted.
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic             err,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             tff_t,
    output logic             tff_rst,
    input  logic             tff_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int IDX_W = $clog2(NREQ);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             q_pre;
    logic [NREQ-1:0]  sel;

    // The shared flop is reset together with the arbiter so an abort leaves both consistent.
    assign tff_rst = rst;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: IDLE waits for any request, then one TOGGLE cycle and one CHECK cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = TOGGLE;
            TOGGLE:  state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Served index, round-robin pointer, pre-toggle q snapshot and success counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= IDX_W'(NREQ - 1);
            idx        <= '0;
            q_pre      <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            case (state)
                IDLE:   if (any_req) idx <= pick_idx;
                TOGGLE: q_pre <= tff_q;
                CHECK: begin
                    rr_ptr <= idx;
                    if (tff_q != q_pre) toggle_cnt <= toggle_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state and idx only; req never reaches them directly.
    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
        grant    = '0;
        ack      = '0;
        err      = 1'b0;
        busy     = 1'b0;
        tff_t    = 1'b0;
        case (state)
            TOGGLE: begin
                tff_t = 1'b1;
                grant = sel;
                busy  = 1'b1;
            end
            CHECK: begin
                grant = sel;
                ack   = sel;
                busy  = 1'b1;
                err   = (tff_q == q_pre);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench for tff_toggle_arbiter with a behavioural shared T flop.
module tb_tff_toggle_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic             err;
    logic [NREQ-1:0]  grant;
    logic             busy;
    logic             tff_t;
    logic             tff_rst;
    logic             tff_q;
    logic [CNT_W-1:0] toggle_cnt;
    logic             stuck;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    tff_toggle_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .err        (err),
        .grant      (grant),
        .busy       (busy),
        .tff_t      (tff_t),
        .tff_rst    (tff_rst),
        .tff_q      (tff_q),
        .toggle_cnt (toggle_cnt)
    );

    // Shared T flop; 'stuck' models its reset being held high externally.
    always_ff @(posedge clk) begin
        if (tff_rst || stuck) tff_q <= 1'b0;
        else if (tff_t)       tff_q <= ~tff_q;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        stuck = 1'b0;
        rst   = 1'b1;
        req   = '0;

        // Reset then idle
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tff_t", 32'(tff_t), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cnt", 32'(toggle_cnt), 0);
        chk("rst_q", 32'(tff_q), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Single request from requester 1
        req = 4'b0010;
        tick();
        chk("single_t", 32'(tff_t), 1);
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_busy", 32'(busy), 1);
        chk("single_noack", 32'(ack), 0);
        tick();
        chk("single_ack", 32'(ack), 32'h2);
        chk("single_err", 32'(err), 0);
        chk("single_t_lo", 32'(tff_t), 0);
        chk("single_q", 32'(tff_q), 1);
        req = '0;
        tick();
        chk("single_cnt", 32'(toggle_cnt), 1);
        chk("single_idle", 32'(busy), 0);
        chk("single_ack_lo", 32'(ack), 0);

        // Fairness: all requesting from a fresh pointer serves 0,1,2,3
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(1 << k));
            tick();
            chk("rr_ack", 32'(ack), 32'(1 << k));
            chk("rr_err", 32'(err), 0);
            tick();
            chk("rr_gap", 32'(busy), 0);
        end
        req = '0;
        chk("rr_cnt", 32'(toggle_cnt), 4);
        chk("rr_q", 32'(tff_q), 0);

        // Pointer wrap: after idx 2, req 0101 serves 0 then 2
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        chk("wrap_ack2", 32'(ack), 32'h4);
        req = 4'b0101;
        tick();
        tick();
        chk("wrap_grant0", 32'(grant), 32'h1);
        tick();
        chk("wrap_ack0", 32'(ack), 32'h1);
        tick();
        tick();
        chk("wrap_grant2", 32'(grant), 32'h4);
        tick();
        chk("wrap_ack2b", 32'(ack), 32'h4);
        req = '0;
        tick();
        chk("wrap_cnt", 32'(toggle_cnt), 3);

        // Stuck flop: ack still issued with err, counter unchanged
        stuck = 1'b1;
        req   = 4'b1000;
        tick();
        tick();
        chk("stuck_ack", 32'(ack), 32'h8);
        chk("stuck_err", 32'(err), 1);
        req = '0;
        tick();
        chk("stuck_cnt", 32'(toggle_cnt), 3);
        stuck = 1'b0;

        // Reset mid-operation: move the pointer to 0 first so restore is observable
        req = 4'b0001;
        tick();
        tick();
        chk("pre_ack0", 32'(ack), 32'h1);
        tick();
        tick();
        chk("abort_t", 32'(tff_t), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'(ack), 0);
        chk("abort_cnt", 32'(toggle_cnt), 0);
        chk("abort_q", 32'(tff_q), 0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        chk("restore_grant", 32'(grant), 32'h1);
        tick();
        chk("restore_ack", 32'(ack), 32'h1);
        req = 4'b1000;
        tick();
        tick();
        chk("restore_grant3", 32'(grant), 32'h8);
        tick();
        chk("restore_ack3", 32'(ack), 32'h8);
        req = '0;
        tick();
        chk("restore_cnt", 32'(toggle_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
